// File: rtl/spike_event_pipe_out.sv
// Spike/tick event framer feeding a first-word-fall-through FIFO for okBTPipeOut readout.
// One header word per sim tick, one word per spike; all logic in the ti_clk domain.
module spike_event_pipe_out #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BLOCK_WORDS = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clear,
  input  logic                  i_sim_tick,
  input  logic                  i_spike_valid,
  input  logic [14:0]           i_spike_id,
  input  logic                  i_ep_read,
  output logic [15:0]           o_ep_datain,
  output logic                  o_ep_ready,
  output logic [DEPTH_LOG2:0]   o_fill_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic [15:0]           o_drop_count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_BLOCK = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);

  logic [15:0]           r_mem [Depth];
  logic [15:0]           r_ram_q;
  logic [15:0]           r_byp;
  logic                  r_byp_sel;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_fill;
  logic [DEPTH_LOG2:0]   r_blk_cnt;
  logic                  r_ready;
  logic [14:0]           r_tick;
  logic                  r_pend_vld;
  logic [14:0]           r_pend_id;
  logic                  r_ovf;
  logic                  r_udf;
  logic [15:0]           r_drop;

  logic                  w_pop;
  logic                  w_room;
  logic                  w_req;
  logic                  w_write;
  logic [15:0]           w_wdata;
  logic                  w_pend_vld_d;
  logic [14:0]           w_pend_id_d;
  logic [1:0]            w_drops;
  logic [16:0]           w_drop_sum;
  logic [DEPTH_LOG2:0]   w_fill_d;
  logic [DEPTH_LOG2:0]   w_blk_cnt_d;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic                  w_byp_d;

  // Write arbitration: header > pending spike > new spike, one write per cycle.
  always_comb begin
    w_pop        = i_ep_read && (r_fill != '0);
    w_room       = (r_fill != LVL_FULL) || w_pop;
    w_req        = 1'b0;
    w_wdata      = 16'h0000;
    w_pend_vld_d = r_pend_vld;
    w_pend_id_d  = r_pend_id;
    w_drops      = 2'd0;
    if (i_sim_tick) begin
      w_req   = 1'b1;
      w_wdata = {1'b1, r_tick};
      if (i_spike_valid) begin
        if (r_pend_vld) begin
          w_drops = w_drops + 2'd1;
        end else begin
          w_pend_vld_d = 1'b1;
          w_pend_id_d  = i_spike_id;
        end
      end
    end else if (r_pend_vld) begin
      w_req        = 1'b1;
      w_wdata      = {1'b0, r_pend_id};
      w_pend_vld_d = i_spike_valid;
      if (i_spike_valid) begin
        w_pend_id_d = i_spike_id;
      end
    end else if (i_spike_valid) begin
      w_req   = 1'b1;
      w_wdata = {1'b0, i_spike_id};
    end
    w_write = w_req && w_room;
    if (w_req && !w_room) begin
      w_drops = w_drops + 2'd1;
    end
  end

  always_comb begin
    w_fill_d   = r_fill + {{DEPTH_LOG2{1'b0}}, w_write} - {{DEPTH_LOG2{1'b0}}, w_pop};
    w_drop_sum = {1'b0, r_drop} + {15'd0, w_drops};
    w_rd_addr  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    // Next head is being written this very cycle: the RAM can't return it yet.
    w_byp_d    = w_write && (w_rd_addr == r_wr_ptr);
    w_blk_cnt_d = r_blk_cnt;
    if (w_pop && r_ready) begin
      w_blk_cnt_d = (r_blk_cnt + 1'b1 == LVL_BLOCK) ? '0 : r_blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
    r_ram_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_blk_cnt  <= '0;
      r_ready    <= 1'b0;
      r_tick     <= '0;
      r_pend_vld <= 1'b0;
      r_pend_id  <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_drop     <= '0;
      r_byp      <= 16'hFFFF;
      r_byp_sel  <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_blk_cnt  <= '0;
      r_ready    <= 1'b0;
      r_tick     <= '0;
      r_pend_vld <= 1'b0;
      r_pend_id  <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_drop     <= '0;
      r_byp      <= 16'hFFFF;
      r_byp_sel  <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_sim_tick) begin
        r_tick <= r_tick + 15'd1;
      end
      if (w_drops != 2'd0) begin
        r_ovf  <= 1'b1;
        r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
      if (i_ep_read && (r_fill == '0)) begin
        r_udf <= 1'b1;
      end
      r_fill     <= w_fill_d;
      r_blk_cnt  <= w_blk_cnt_d;
      // Held high while a block is being read out, otherwise tracks the threshold.
      r_ready    <= (w_blk_cnt_d != '0) || (w_fill_d >= LVL_BLOCK);
      r_pend_vld <= w_pend_vld_d;
      r_pend_id  <= w_pend_id_d;
      r_byp      <= w_wdata;
      r_byp_sel  <= w_byp_d;
    end
  end

  assign o_ep_datain  = (r_fill == '0) ? 16'hFFFF : (r_byp_sel ? r_byp : r_ram_q);
  assign o_ep_ready   = r_ready;
  assign o_fill_count = r_fill;
  assign o_overflow   = r_ovf;
  assign o_underflow  = r_udf;
  assign o_drop_count = r_drop;

endmodule

// File: doc/spike_event_pipe_out.md
Name: spike_event_pipe_out

Overview:
- Turns MN spike events into a 16-bit word stream for host readout over an okBTPipeOut endpoint.
- This is the readout direction; the existing pipe-in path fills waveform BRAM.
- Runs entirely in the ti_clk domain. Spike and tick pulses arrive already synchronized to it.
- Output stream: one header word per simulation tick, followed by one word per spike ID seen in that tick. Host parses frames offline.

Parameters:
- DEPTH_LOG2, 10, FIFO depth is 2^DEPTH_LOG2 words (1024).
- BLOCK_WORDS, 64, BTPipe block size in words; ep_ready threshold. Must be ≤ 2^DEPTH_LOG2.

Ports:
- clk  in  1  ti_clk.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active-high.
- sim_tick  in  1  one-cycle pulse marking a sim_clk step.
- spike_valid  in  1  one-cycle pulse: spike_id is valid.
- spike_id  in  15  neuron/MU index.
- ep_read  in  1  pop strobe from okBTPipeOut.
- ep_datain  out  16  head word to the pipe.
- ep_ready  out  1  a full block is available.
- fill_count  out  DEPTH_LOG2+1  words currently stored.
- overflow  out  1  sticky: a word was dropped.
- underflow  out  1  sticky: a read occurred while empty.
- drop_count  out  16  number of dropped words, saturating.

Behaviour:
- Word formats:
  - Header: {1'b1, tick_cnt[14:0]}.
  - Spike: {1'b0, spike_id[14:0]}.
- tick_cnt: 15-bit, 0 after reset. Increments on every sim_tick, after the header is built with the old value. Wraps 32767→0.
- Write arbitration: at most one FIFO write per cycle. Priority is header > pending spike > new spike.
- Pending register (1 entry):
  - A spike that loses arbitration goes into the pending register.
  - If pending is already occupied and still not written this cycle, the new spike is dropped.
- sim_tick and spike_valid in the same cycle: the header is written that cycle. The spike belongs to the new tick and is written from pending on the next free cycle.
- Full FIFO:
  - The word being written (header, pending or new spike) is dropped.
  - overflow is set; drop_count increments, saturating at 16'hFFFF.
  - tick_cnt still increments on a dropped header.
  - A dropped pending word frees pending.
- Simultaneous write and ep_read when full: the read frees a slot and the write is accepted; fill_count is unchanged.
- Reads are first-word-fall-through:
  - ep_datain presents the head word, registered.
  - A word written into an empty FIFO at cycle t appears on ep_datain at t+1.
  - ep_read at cycle t pops; the next word (or 16'hFFFF if now empty) appears at t+1.
- ep_read while empty: no pop, ep_datain stays 16'hFFFF, underflow is set. Any write in the same cycle proceeds normally.
- Pointers wrap modulo 2^DEPTH_LOG2. fill_count ranges 0..2^DEPTH_LOG2.
- ep_ready is registered: high one cycle after fill_count ≥ BLOCK_WORDS, low one cycle after it drops below. It does not deassert mid-block on its own; the host reads exactly BLOCK_WORDS per block.
- Reset (reset_n low, asynchronous, at any time including mid-block):
  - Pointers, fill_count, pending, tick_cnt, overflow, underflow and drop_count go to 0.
  - ep_datain = 16'hFFFF, ep_ready = 0.
  - Stored data is discarded.
- clear: same end state as reset, applied at the clock edge. clear overrides any write or read in that cycle.
- Storage is inferred block RAM (1 write port, 1 read port). The read path is prefetched so FWFT holds with single-cycle read latency.

Test Plan:
- Ordering: reset, 3 sim_ticks with spike_id 5 one cycle after each tick, then pop 6 words. Expect 8000, 0005, 8001, 0005, 8002, 0005; fill_count returns to 0; underflow = 0.
- Collision: sim_tick and spike_valid(id=0x0123) in the same cycle, then a second spike 0x0044 on the next cycle. Expect stream 8000, 0123, 0044; no drops.
- ep_ready threshold: with BLOCK_WORDS=64, write 63 words → ep_ready = 0. Write the 64th → ep_ready = 1 the following cycle. Pop 64 words → ep_ready = 0 one cycle after the last pop.
- Overflow: fill all 1024 words, then 5 more spikes → fill_count = 1024, drop_count = 5, overflow = 1. Simultaneous read and write when full → write accepted, fill_count = 1024.
- Underflow and wrap: ep_read while empty → ep_datain = FFFF, underflow = 1. Force 32768 ticks → header wraps from FFFF to 8000. Write and read across the pointer wrap → data intact.
- Reset mid-block: assert reset_n low during a 64-word read → all outputs are at reset values immediately. After release, the first header is 8000.
